// File: rtl/hilo_muldiv_pkg.sv
// Shared CPU definitions: ALU encoding, mult/div operation codes and the
// mult/div sequencer state encoding.
package hilo_muldiv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  // Plain vector encoding so the state register stays a simple 2-bit flop.
  typedef logic [1:0] muldiv_state_t;
  localparam muldiv_state_t ST_IDLE = 2'd0;
  localparam muldiv_state_t ST_CALC = 2'd1;
  localparam muldiv_state_t ST_FIX  = 2'd2;

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_core.sv
// Iterative 32-cycle engine: shift-add multiply (LSB first) and restoring
// divide (MSB first) on magnitudes, with sign correction in the FIX cycle.
//
//   state   | meaning
//   IDLE    | waiting for start, operands latched on start
//   CALC    | one multiplier/quotient bit per cycle, cnt 31..0
//   FIX     | sign correction, result presented with fix=1
module hilo_muldiv_core
  import hilo_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  muldiv_op_t  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        fix,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  muldiv_state_t state;
  logic [4:0]  cnt;
  logic [31:0] acc;
  logic [31:0] sreg;
  logic [31:0] opnd;
  logic [31:0] a_raw;
  logic        is_div;
  logic        div0;
  logic        neg_q;
  logic        neg_r;

  logic        signed_op;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        div_bit;
  logic [31:0] div_rem;
  logic [63:0] prod_fix;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign signed_op = ~op[0];
  assign busy      = (state != ST_IDLE);
  assign fix       = (state == ST_FIX);

  assign mul_sum   = {1'b0, acc} + (sreg[0] ? {1'b0, opnd} : 33'd0);
  assign div_shift = {acc, sreg[31]};
  assign div_bit   = (div_shift >= {1'b0, opnd});
  // The restored remainder is always below the divisor, so 32 bits suffice.
  assign div_diff  = div_shift[31:0] - opnd;
  assign div_rem   = div_bit ? div_diff : div_shift[31:0];

  assign prod_fix  = neg_q ? (~{acc, sreg} + 64'd1) : {acc, sreg};
  assign q_fix     = neg_q ? (~sreg + 32'd1) : sreg;
  assign r_fix     = neg_r ? (~acc + 32'd1) : acc;

  always_comb begin
    res_hi = prod_fix[63:32];
    res_lo = prod_fix[31:0];
    if (is_div) begin
      if (div0) begin
        res_hi = a_raw;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = r_fix;
        res_lo = q_fix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= 5'd0;
      acc    <= 32'd0;
      sreg   <= 32'd0;
      opnd   <= 32'd0;
      a_raw  <= 32'd0;
      is_div <= 1'b0;
      div0   <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            is_div <= op[1];
            a_raw  <= a;
            div0   <= op[1] && (b == 32'd0);
            neg_q  <= signed_op && (a[31] ^ b[31]);
            neg_r  <= signed_op && a[31];
            acc    <= 32'd0;
            cnt    <= 5'd31;
            state  <= ST_CALC;
            if (op[1]) begin
              sreg <= magnitude(a, signed_op);
              opnd <= magnitude(b, signed_op);
            end else begin
              sreg <= magnitude(b, signed_op);
              opnd <= magnitude(a, signed_op);
            end
          end
        end
        ST_CALC: begin
          if (is_div) begin
            acc  <= div_rem;
            sreg <= {sreg[30:0], div_bit};
          end else begin
            acc  <= mul_sum[32:1];
            sreg <= {mul_sum[0], sreg[31:1]};
          end
          if (cnt == 5'd0) state <= ST_FIX;
          else             cnt   <= cnt - 5'd1;
        end
        ST_FIX:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO architectural registers with MTHI/MTLO writes, fed by the iterative
// mult/div engine; busy stalls dependent instructions in the control unit.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic        core_busy;
  logic        core_fix;
  logic [31:0] core_hi;
  logic [31:0] core_lo;

  assign busy = core_busy;

  hilo_muldiv_core u_core (
    .clk    (clk),
    .reset  (reset),
    .start  (start & ~core_busy),
    .op     (muldiv_op_t'(op)),
    .a      (a),
    .b      (b),
    .busy   (core_busy),
    .fix    (core_fix),
    .res_hi (core_hi),
    .res_lo (core_lo)
  );

  // A start in IDLE takes priority; moves issued alongside it are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi   <= 32'd0;
      lo   <= 32'd0;
      done <= 1'b0;
    end else begin
      done <= core_fix;
      if (core_fix) begin
        hi <= core_hi;
        lo <= core_lo;
      end else if (!core_busy && !start) begin
        if (mthi) hi <= wdata;
        if (mtlo) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench: expected HI/LO pushed per issued op, monitor checks on done.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp  = 0;
  int n_fail = 0;
  int done_seen = 0;
  logic [63:0] sb[$];
  logic [31:0] mhi, mlo;

  hilo_muldiv dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_seen++;
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        check("result_hi", {32'd0, hi}, {32'd0, e[63:32]});
        check("result_lo", {32'd0, lo}, {32'd0, e[31:0]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: plain; 1: second start + MTLO during busy; 2: MTHI alongside start
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] ehi,
                        input logic [31:0] elo, input int mode);
    int bad_busy = 0;
    int bad_hold = 0;
    sb.push_back({ehi, elo});
    start = 1'b1; op = o; a = x; b = y;
    if (mode == 2) begin mthi = 1'b1; wdata = 32'h0000_5555; end
    step();
    start = 1'b0; mthi = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      if (busy !== 1'b1) bad_busy++;
      if (hi !== mhi || lo !== mlo) bad_hold++;
      if (mode == 1 && c == 5) begin
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
        mtlo = 1'b1; wdata = 32'h0000_DEAD;
      end
      step();
      start = 1'b0; mtlo = 1'b0;
    end
    check({name, "_busy_window"}, 64'(bad_busy), 64'd0);
    check({name, "_hold"}, 64'(bad_hold), 64'd0);
    check({name, "_done_c34"}, {62'd0, busy, done}, 64'd1);
    mhi = ehi; mlo = elo;
    if (mode == 1) begin
      step();
      check({name, "_no_restart"}, {63'd0, busy}, 64'd0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    mhi = '0; mlo = '0;
    step();
    step();
    reset = 1'b0;
    check("reset_hi",   {32'd0, hi}, 64'd0);
    check("reset_lo",   {32'd0, lo}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
    run_op("divu_zero", 2'b11, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 0);

    mthi = 1'b1; wdata = 32'h0000_1234;
    step();
    mthi = 1'b0;
    mhi = 32'h0000_1234;
    check("mthi_hi", {32'd0, hi}, {32'd0, mhi});
    check("mthi_lo", {32'd0, lo}, {32'd0, mlo});

    run_op("divu_busy", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1);

    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hAAAA_5555;
    step();
    mthi = 1'b0; mtlo = 1'b0;
    mhi = 32'hAAAA_5555; mlo = 32'hAAAA_5555;
    check("mt_both", {hi, lo}, {mhi, mlo});

    run_op("start_wins", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 2);

    // Reset mid-operation: no expectation queued, so any done is an error.
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    step();
    start = 1'b0;
    for (int c = 1; c < 10; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_done", {63'd0, done}, 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    for (int c = 0; c < 40; c++) step();

    check("done_count", 64'(done_seen), 64'd7);
    check("queue_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
